// File: rtl/trdb_rst_seq.sv
// Reset sequencer: holds NUM_CH active-low resets, releases them in ascending order, re-asserts descending on eos_i.
// Optional TRDB_RST_SEQ_SWREQ_EN adds sw_req_i to restart the sequence from RUN or OFF.
module trdb_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eos_i,
`ifdef TRDB_RST_SEQ_SWREQ_EN
  input  logic              sw_req_i,
`endif
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              all_rel_o,
  output logic              busy_o,
  output logic [2:0]        state_o
);

  localparam int     HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam longint CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

  if (STAGE_GAP < 1 || NUM_CH < 1 || longint'(HOLD_EFF) > CNT_MAX ||
      longint'(STAGE_GAP) > CNT_MAX) begin : g_bad_params
    $error("trdb_rst_seq: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_RELEASE  = 3'd1,
    S_RUN      = 3'd2,
    S_SHUTDOWN = 3'd3,
    S_OFF      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_CH-1:0] mask, mask_nxt;
  logic [NUM_CH-1:0] rel, rel_nxt;
  logic              all_rel, all_rel_nxt;
  logic [NUM_CH-1:0] pending, lo_pend, hi_rel;
  logic              sw_restart;

`ifdef TRDB_RST_SEQ_SWREQ_EN
  assign sw_restart = sw_req_i;
`else
  assign sw_restart = 1'b0;
`endif

  // lowest-index channel still waiting for release (isolate lowest set bit)
  assign pending = mask & ~rel;
  assign lo_pend = pending & (~pending + NUM_CH'(1));

  always_comb begin
    hi_rel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rel[i]) begin
        hi_rel    = '0;
        hi_rel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mask_nxt    = mask;
    rel_nxt     = rel;
    all_rel_nxt = all_rel;
    case (state)
      S_HOLD: begin
        if (eos_i) begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = '0;
          mask_nxt  = ch_mask_i;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (eos_i) begin
          state_nxt   = S_SHUTDOWN;
          cnt_nxt     = '0;
          all_rel_nxt = 1'b0;
          rel_nxt     = rel & ~hi_rel;
        end else if (pending == '0) begin
          state_nxt   = S_RUN;
          cnt_nxt     = '0;
          all_rel_nxt = 1'b1;
        end else if (rel == '0 || cnt == GAP_LAST) begin
          // first slot fires on entry, later ones every STAGE_GAP edges
          rel_nxt = rel | lo_pend;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (eos_i) begin
          state_nxt   = S_SHUTDOWN;
          cnt_nxt     = '0;
          all_rel_nxt = 1'b0;
          rel_nxt     = rel & ~hi_rel;
        end else if (sw_restart) begin
          state_nxt   = S_HOLD;
          cnt_nxt     = '0;
          all_rel_nxt = 1'b0;
          rel_nxt     = '0;
        end
      end
      S_SHUTDOWN: begin
        if (rel == '0) begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          rel_nxt = rel & ~hi_rel;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (sw_restart) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt   = S_HOLD;
        cnt_nxt     = '0;
        rel_nxt     = '0;
        all_rel_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_HOLD;
      cnt     <= '0;
      mask    <= '0;
      rel     <= '0;
      all_rel <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mask    <= mask_nxt;
      rel     <= rel_nxt;
      all_rel <= all_rel_nxt;
    end
  end

  assign rst_n_o   = rel;
  assign all_rel_o = all_rel;
  assign busy_o    = (state == S_HOLD) || (state == S_RELEASE) || (state == S_SHUTDOWN);
  assign state_o   = state;

endmodule

// File: tb/tb_trdb_rst_seq.sv
// Bench for trdb_rst_seq: directed and random scenarios checked against an edge-schedule model.
module tb_trdb_rst_seq;

  localparam int NCH = 4;
  localparam int H   = 16;
  localparam int G   = 2;
  localparam int BIG = 1 << 30;

  logic           clk = 1'b0;
  logic           rst;
  logic           eos;
  logic [NCH-1:0] mask_in;
  logic [NCH-1:0] rst_n;
  logic           all_rel;
  logic           busy;
  logic [2:0]     state;

  int n_chk  = 0;
  int n_fail = 0;

  logic [NCH-1:0] sc_mask;
  int             sc_eos;

  always #5 clk = ~clk;

  trdb_rst_seq #(
    .NUM_CH(NCH), .CNT_W(8), .HOLD_CYCLES(H), .STAGE_GAP(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eos_i(eos),
    .ch_mask_i(mask_in),
    .rst_n_o(rst_n),
    .all_rel_o(all_rel),
    .busy_o(busy),
    .state_o(state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs after edge e, derived from release/re-assert edge times.
  task automatic model(input int e, output logic [2:0] st, output logic [NCH-1:0] rn, output logic ar);
    int rel_t[NCH];
    int drop_t[NCH];
    int n;
    int nrel;
    int run_t;
    int off_t;
    n = 0;
    for (int i = 0; i < NCH; i++) begin
      rel_t[i] = BIG;
      if (sc_mask[i]) begin
        rel_t[i] = H + 1 + n * G;
        n++;
      end
    end
    run_t = (n == 0) ? H + 1 : H + 2 + (n - 1) * G;
    st = 3'd0;
    rn = '0;
    ar = 1'b0;
    if (sc_eos != 0 && sc_eos <= H) begin
      st = (e >= sc_eos) ? 3'd4 : 3'd0;
    end else if (sc_eos == 0 || e < sc_eos) begin
      for (int i = 0; i < NCH; i++) rn[i] = (e >= rel_t[i]);
      st = (e < H) ? 3'd0 : (e < run_t) ? 3'd1 : 3'd2;
      ar = (e >= run_t);
    end else begin
      nrel = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
        drop_t[i] = 0;
        if (rel_t[i] < sc_eos) begin
          drop_t[i] = sc_eos + nrel * G;
          nrel++;
        end
      end
      for (int i = 0; i < NCH; i++) rn[i] = (rel_t[i] < sc_eos) && (e < drop_t[i]);
      off_t = (nrel == 0) ? sc_eos + 1 : sc_eos + (nrel - 1) * G + 1;
      st = (e >= off_t) ? 3'd4 : 3'd3;
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_rst_n"}, 32'(rst_n), 32'd0);
    check_eq({tag, "_all_rel"}, 32'(all_rel), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic drive_for_edge(input int e, input logic [NCH-1:0] m, input int eos_e, input int rst_e);
    eos     = (eos_e != 0) && (e >= eos_e);
    mask_in = (e == H) ? m : NCH'($urandom);
    rst     = (e == rst_e);
  endtask

  task automatic run_scenario(input logic [NCH-1:0] m, input int eos_e, input int rst_e, input int len);
    logic [2:0]     st;
    logic [NCH-1:0] rn;
    logic           ar;
    sc_mask = m;
    sc_eos  = eos_e;
    rst     = 1'b1;
    eos     = 1'b0;
    mask_in = NCH'($urandom);
    repeat (5) @(posedge clk);
    #1;
    check_reset("reset");
    drive_for_edge(1, m, eos_e, rst_e);
    for (int e = 1; e <= len; e++) begin
      @(posedge clk);
      #1;
      if (e == rst_e) begin
        check_reset($sformatf("mid_rst_e%0d", e));
        break;
      end
      model(e, st, rn, ar);
      check_eq($sformatf("state_m%b_eos%0d_e%0d", m, eos_e, e), 32'(state), 32'(st));
      check_eq($sformatf("rst_n_m%b_eos%0d_e%0d", m, eos_e, e), 32'(rst_n), 32'(rn));
      check_eq($sformatf("all_rel_m%b_eos%0d_e%0d", m, eos_e, e), 32'(all_rel), 32'(ar));
      check_eq($sformatf("busy_m%b_eos%0d_e%0d", m, eos_e, e), 32'(busy),
               32'(st == 3'd0 || st == 3'd1 || st == 3'd3));
      drive_for_edge(e + 1, m, eos_e, rst_e);
    end
  endtask

  initial begin
    rst     = 1'b1;
    eos     = 1'b0;
    mask_in = '0;
    run_scenario(4'b1111, 0, 0, 40);
    run_scenario(4'b1010, 0, 0, 40);
    run_scenario(4'b1111, 30, 0, 45);
    run_scenario(4'b1111, 10, 0, 30);
    run_scenario(4'b1111, 20, 0, 30);
    run_scenario(4'b1111, 0, 21, 30);
    run_scenario(4'b0000, 0, 0, 25);
    run_scenario(4'b0000, 20, 0, 30);
    run_scenario(4'b0101, 16, 0, 25);
    run_scenario(4'b1111, 17, 0, 25);
    run_scenario(4'b1000, 24, 0, 35);
    for (int k = 0; k < 25; k++) begin
      int eos_e;
      int rst_e;
      eos_e = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 45));
      rst_e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_scenario(NCH'($urandom_range(0, 15)), eos_e, rst_e, 50);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
